// File: rtl/hazard_stall_ctrl_pkg.sv
// Shared core definitions for the pipeline sequencer.
//   - sequencer state encodings
//   - HLT opcode and the hard-wired zero register specifier
//   - wait-counter width
package hazard_stall_ctrl_pkg;

    localparam logic [1:0] ST_RUN      = 2'd0;
    localparam logic [1:0] ST_MEM_WAIT = 2'd1;
    localparam logic [1:0] ST_HALTED   = 2'd2;

    localparam logic [3:0] OPC_HLT  = 4'hF;
    localparam logic [3:0] REG_ZERO = 4'd0;

    localparam int WAIT_W = 8;

endpackage

// File: rtl/hazard_stall_ctrl_sat_counter.sv
// Saturating up-counter used for the sequencer's performance counters.
// Ports:
//   clk    core clock
//   clr    synchronous clear (highest priority)
//   inc    count this cycle
//   count  current value; holds at all-ones instead of wrapping
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencer for the 5-stage core. Detects load-use hazards the
// forwarding network cannot cover, freezes the pipe on memory wait, flushes
// the wrong path on a taken branch resolved in X and retires the core on HLT.
//
// state     | meaning
// ----------+----------------------------------------------
// RUN       | normal issue
// MEM_WAIT  | memory not ready, pipe frozen, wait counter running
// HALTED    | HLT retired, everything held until rst
//
// Ports:
//   clk, rst                     core clock, synchronous active-high reset
//   mem_read_de, dst_reg_de      load in D/E and its destination
//   rs_fd, rt_fd, uses_rs_fd,
//   uses_rt_fd, mem_write_fd     source usage of the F/D instruction
//   branch_taken_x               taken branch resolved in X
//   halt_fd, halt_mw             HLT in F/D / in M/W
//   mem_busy                     D- or I-memory not ready
//   stall_pc, stall_fd,
//   stall_pipe                   hold PC / F/D / D/E..M/W
//   flush_fd, bubble_de          NOP into F/D / D/E
//   halted                       core retired
//   mem_timeout                  sticky memory-wait timeout
//   stall_cnt, flush_cnt         saturating performance counters
module hazard_stall_ctrl
    import hazard_stall_ctrl_pkg::*;
#(
    parameter int REG_W    = 4,
    parameter int CNT_W    = 16,
    parameter int WAIT_MAX = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mem_read_de,
    input  logic [REG_W-1:0] dst_reg_de,
    input  logic [REG_W-1:0] rs_fd,
    input  logic [REG_W-1:0] rt_fd,
    input  logic             uses_rs_fd,
    input  logic             uses_rt_fd,
    input  logic             mem_write_fd,
    input  logic             branch_taken_x,
    input  logic             halt_fd,
    input  logic             halt_mw,
    input  logic             mem_busy,
    output logic             stall_pc,
    output logic             stall_fd,
    output logic             stall_pipe,
    output logic             flush_fd,
    output logic             bubble_de,
    output logic             halted,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(WAIT_MAX);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [WAIT_W-1:0] wait_nxt;
    logic              lu_hazard;
    logic              stall_inc;
    logic              flush_inc;

    // A store whose only dependency is rt gets its data through the m2m path,
    // so only the rs match (or a non-store rt match) forces a stall.
    assign lu_hazard = mem_read_de && (dst_reg_de != REG_W'(REG_ZERO)) &&
                       ((uses_rs_fd && (rs_fd == dst_reg_de)) ||
                        (uses_rt_fd && !mem_write_fd && (rt_fd == dst_reg_de)));

    always_comb begin
        stall_pc   = 1'b0;
        stall_fd   = 1'b0;
        stall_pipe = 1'b0;
        flush_fd   = 1'b0;
        bubble_de  = 1'b0;
        halted     = 1'b0;
        if (rst) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
        end else if (state == ST_HALTED) begin
            stall_pc   = 1'b1;
            stall_fd   = 1'b1;
            stall_pipe = 1'b1;
            halted     = 1'b1;
        end else if (mem_busy) begin
            // X is frozen, so a pending taken branch is replayed once memory is ready
            stall_pc   = 1'b1;
            stall_fd   = 1'b1;
            stall_pipe = 1'b1;
        end else if (branch_taken_x) begin
            flush_fd  = 1'b1;
            bubble_de = 1'b1;
        end else if (lu_hazard) begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            bubble_de = 1'b1;
        end else if (halt_fd) begin
            stall_pc = 1'b1;
        end
    end

    always_comb begin
        state_nxt = ST_RUN;
        case (state)
            ST_HALTED: state_nxt = ST_HALTED;
            default: begin
                if (halt_mw && !mem_busy) begin
                    state_nxt = ST_HALTED;
                end else if (mem_busy) begin
                    state_nxt = ST_MEM_WAIT;
                end else begin
                    state_nxt = ST_RUN;
                end
            end
        endcase
    end

    // Counts MEM_WAIT cycles; holds at all-ones so it cannot wrap past the limit.
    always_comb begin
        wait_nxt = '0;
        if ((state == ST_MEM_WAIT) && mem_busy) begin
            wait_nxt = (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_RUN;
            wait_cnt    <= '0;
            mem_timeout <= 1'b0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_nxt;
            if ((state == ST_MEM_WAIT) && mem_busy && (wait_nxt == WAIT_LIMIT)) begin
                mem_timeout <= 1'b1;
            end
        end
    end

    assign stall_inc = !rst && stall_pc && (state != ST_HALTED);
    assign flush_inc = !rst && flush_fd;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (stall_inc),
        .count (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (rst),
        .inc   (flush_inc),
        .count (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Testbench for hazard_stall_ctrl: directed scenarios with literal expectations
// plus a randomized run checked every cycle against a behavioural model.
module tb_hazard_stall_ctrl;

    localparam int REG_W    = 4;
    localparam int CNT_W    = 8;
    localparam int WAIT_MAX = 255;
    localparam int CNT_MAX  = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst = 1'b1;
    logic             mem_read_de = 1'b0;
    logic [REG_W-1:0] dst_reg_de = '0;
    logic [REG_W-1:0] rs_fd = '0;
    logic [REG_W-1:0] rt_fd = '0;
    logic             uses_rs_fd = 1'b0;
    logic             uses_rt_fd = 1'b0;
    logic             mem_write_fd = 1'b0;
    logic             branch_taken_x = 1'b0;
    logic             halt_fd = 1'b0;
    logic             halt_mw = 1'b0;
    logic             mem_busy = 1'b0;
    logic             stall_pc, stall_fd, stall_pipe, flush_fd, bubble_de, halted, mem_timeout;
    logic [CNT_W-1:0] stall_cnt, flush_cnt;

    hazard_stall_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .WAIT_MAX(WAIT_MAX)) dut (
        .clk            (clk),
        .rst            (rst),
        .mem_read_de    (mem_read_de),
        .dst_reg_de     (dst_reg_de),
        .rs_fd          (rs_fd),
        .rt_fd          (rt_fd),
        .uses_rs_fd     (uses_rs_fd),
        .uses_rt_fd     (uses_rt_fd),
        .mem_write_fd   (mem_write_fd),
        .branch_taken_x (branch_taken_x),
        .halt_fd        (halt_fd),
        .halt_mw        (halt_mw),
        .mem_busy       (mem_busy),
        .stall_pc       (stall_pc),
        .stall_fd       (stall_fd),
        .stall_pipe     (stall_pipe),
        .flush_fd       (flush_fd),
        .bubble_de      (bubble_de),
        .halted         (halted),
        .mem_timeout    (mem_timeout),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: tracks whether the core has retired, how long memory
    // has been continuously busy, and the counter values.
    bit m_valid   = 1'b0;
    bit m_halted  = 1'b0;
    bit m_timeout = 1'b0;
    int m_busy_run = 0;
    int m_stall    = 0;
    int m_flush    = 0;

    always @(negedge clk) begin
        bit lu;
        bit e_pc, e_fd, e_pipe, e_flush, e_bub, e_halt;
        lu = mem_read_de && (dst_reg_de != 0) &&
             ((uses_rs_fd && rs_fd == dst_reg_de) ||
              (uses_rt_fd && !mem_write_fd && rt_fd == dst_reg_de));
        e_pc = 0; e_fd = 0; e_pipe = 0; e_flush = 0; e_bub = 0; e_halt = 0;
        if (rst) begin
            e_flush = 1; e_bub = 1;
        end else if (m_halted) begin
            e_pc = 1; e_fd = 1; e_pipe = 1; e_halt = 1;
        end else if (mem_busy) begin
            e_pc = 1; e_fd = 1; e_pipe = 1;
        end else if (branch_taken_x) begin
            e_flush = 1; e_bub = 1;
        end else if (lu) begin
            e_pc = 1; e_fd = 1; e_bub = 1;
        end else if (halt_fd) begin
            e_pc = 1;
        end
        chk("m_stall_pc",   int'(stall_pc),   int'(e_pc));
        chk("m_stall_fd",   int'(stall_fd),   int'(e_fd));
        chk("m_stall_pipe", int'(stall_pipe), int'(e_pipe));
        chk("m_flush_fd",   int'(flush_fd),   int'(e_flush));
        chk("m_bubble_de",  int'(bubble_de),  int'(e_bub));
        chk("m_halted",     int'(halted),     int'(e_halt));
        if (m_valid) begin
            chk("m_mem_timeout", int'(mem_timeout), int'(m_timeout));
            chk("m_stall_cnt",   int'(stall_cnt),   m_stall);
            chk("m_flush_cnt",   int'(flush_cnt),   m_flush);
        end
        if (rst) begin
            m_valid = 1; m_halted = 0; m_timeout = 0;
            m_busy_run = 0; m_stall = 0; m_flush = 0;
        end else begin
            if (e_pc && !m_halted && m_stall < CNT_MAX) m_stall++;
            if (e_flush && m_flush < CNT_MAX) m_flush++;
            if (!m_halted) begin
                if (mem_busy) begin
                    if (m_busy_run < 100000) m_busy_run++;
                end else begin
                    m_busy_run = 0;
                end
                // first busy cycle is spent in RUN; the rest are MEM_WAIT cycles
                if (m_busy_run - 1 >= WAIT_MAX) m_timeout = 1;
                if (halt_mw && !mem_busy) m_halted = 1;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        mem_read_de = 0; dst_reg_de = '0; rs_fd = '0; rt_fd = '0;
        uses_rs_fd = 0; uses_rt_fd = 0; mem_write_fd = 0;
        branch_taken_x = 0; halt_fd = 0; halt_mw = 0; mem_busy = 0;
    endtask

    task automatic do_reset();
        rst = 1;
        clear_inputs();
        cyc();
        cyc();
        rst = 0;
    endtask

    int burst;

    initial begin
        clear_inputs();
        rst = 1;
        @(negedge clk);
        chk("rst_flush_fd",  int'(flush_fd),  1);
        chk("rst_bubble_de", int'(bubble_de), 1);
        chk("rst_stall_pc",  int'(stall_pc),  0);
        cyc();
        rst = 0;
        @(negedge clk);
        chk("rst_halted",      int'(halted),      0);
        chk("rst_mem_timeout", int'(mem_timeout), 0);
        chk("rst_stall_cnt",   int'(stall_cnt),   0);
        chk("rst_flush_cnt",   int'(flush_cnt),   0);

        // 1: load-use on rs
        do_reset();
        mem_read_de = 1; dst_reg_de = 4'd3; rs_fd = 4'd3; uses_rs_fd = 1;
        @(negedge clk);
        chk("t1_stall_pc",   int'(stall_pc),   1);
        chk("t1_stall_fd",   int'(stall_fd),   1);
        chk("t1_bubble_de",  int'(bubble_de),  1);
        chk("t1_stall_pipe", int'(stall_pipe), 0);
        cyc();
        clear_inputs();
        @(negedge clk);
        chk("t1_clear_stall_pc", int'(stall_pc),  0);
        chk("t1_stall_cnt",      int'(stall_cnt), 1);

        // 2: store rt match and R0 destination do not stall
        cyc();
        mem_read_de = 1; dst_reg_de = 4'd3; rt_fd = 4'd3; uses_rt_fd = 1; mem_write_fd = 1;
        @(negedge clk);
        chk("t2_store_stall_pc", int'(stall_pc), 0);
        cyc();
        clear_inputs();
        mem_read_de = 1; dst_reg_de = 4'd0; rs_fd = 4'd0; uses_rs_fd = 1;
        @(negedge clk);
        chk("t2_r0_stall_pc", int'(stall_pc), 0);

        // 3: branch overrides load-use
        do_reset();
        mem_read_de = 1; dst_reg_de = 4'd5; rs_fd = 4'd5; uses_rs_fd = 1; branch_taken_x = 1;
        @(negedge clk);
        chk("t3_flush_fd",  int'(flush_fd),  1);
        chk("t3_bubble_de", int'(bubble_de), 1);
        chk("t3_stall_pc",  int'(stall_pc),  0);
        cyc();
        clear_inputs();
        @(negedge clk);
        chk("t3_flush_cnt", int'(flush_cnt), 1);

        // 4: branch held through 3 busy cycles
        do_reset();
        mem_busy = 1; branch_taken_x = 1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_frozen_stall_pipe", int'(stall_pipe), 1);
            chk("t4_frozen_flush_fd",   int'(flush_fd),   0);
            cyc();
        end
        mem_busy = 0;
        @(negedge clk);
        chk("t4_flush_fd", int'(flush_fd), 1);
        chk("t4_stall_pc", int'(stall_pc), 0);
        cyc();
        clear_inputs();
        @(negedge clk);
        chk("t4_flush_cnt", int'(flush_cnt), 1);

        // 5: memory timeout after 256 busy cycles, sticky until rst
        do_reset();
        mem_busy = 1;
        repeat (255) cyc();
        @(negedge clk);
        chk("t5_timeout_before", int'(mem_timeout), 0);
        cyc();
        mem_busy = 0;
        @(negedge clk);
        chk("t5_timeout_set", int'(mem_timeout), 1);
        repeat (5) cyc();
        @(negedge clk);
        chk("t5_timeout_sticky", int'(mem_timeout), 1);
        rst = 1;
        cyc();
        rst = 0;
        @(negedge clk);
        chk("t5_timeout_cleared", int'(mem_timeout), 0);

        // 6: halt sequence
        do_reset();
        halt_fd = 1;
        @(negedge clk);
        chk("t6_halt_fd_stall_pc", int'(stall_pc), 1);
        chk("t6_halt_fd_stall_fd", int'(stall_fd), 0);
        cyc();
        halt_fd = 0; halt_mw = 1;
        @(negedge clk);
        chk("t6_not_yet_halted", int'(halted), 0);
        cyc();
        halt_mw = 0;
        @(negedge clk);
        chk("t6_halted",     int'(halted),     1);
        chk("t6_stall_pipe", int'(stall_pipe), 1);
        cyc();
        rst = 1;
        @(negedge clk);
        chk("t6_rst_halted",   int'(halted),   0);
        chk("t6_rst_stall_pc", int'(stall_pc), 0);
        cyc();
        rst = 0;
        @(negedge clk);
        chk("t6_run_halted", int'(halted), 0);

        // counter saturation
        do_reset();
        mem_read_de = 1; dst_reg_de = 4'd7; rs_fd = 4'd7; uses_rs_fd = 1;
        repeat (CNT_MAX + 20) cyc();
        @(negedge clk);
        chk("sat_stall_cnt", int'(stall_cnt), CNT_MAX);
        clear_inputs();
        branch_taken_x = 1;
        repeat (CNT_MAX + 20) cyc();
        @(negedge clk);
        chk("sat_flush_cnt", int'(flush_cnt), CNT_MAX);

        // randomized run
        do_reset();
        burst = 0;
        for (int i = 0; i < 5000; i++) begin
            rst = m_halted ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 199) == 0);
            if (burst > 0) begin
                mem_busy = 1; burst--;
            end else if ($urandom_range(0, 7) == 0) begin
                mem_busy = 1; burst = $urandom_range(0, 5);
            end else begin
                mem_busy = 0;
            end
            mem_read_de    = ($urandom_range(0, 9) < 5);
            dst_reg_de     = REG_W'($urandom_range(0, 3));
            rs_fd          = REG_W'($urandom_range(0, 3));
            rt_fd          = REG_W'($urandom_range(0, 3));
            uses_rs_fd     = $urandom_range(0, 1) == 1;
            uses_rt_fd     = $urandom_range(0, 1) == 1;
            mem_write_fd   = $urandom_range(0, 3) == 0;
            branch_taken_x = $urandom_range(0, 6) == 0;
            halt_fd        = $urandom_range(0, 9) == 0;
            halt_mw        = $urandom_range(0, 59) == 0;
            cyc();
        end
        clear_inputs();
        rst = 0;
        cyc();
        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
